// File: rtl/scene_renderer_pkg.sv
// Shared game geometry for the scene renderer: tile grid, block field,
// walls, paddle/ball sizes, colours and the per-row block palette.
package scene_renderer_pkg;

    // Beam position to RGB output delay in clocks
    localparam int LATENCY = 3;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Tiles are 8x8 pixels
    localparam int TILE_SHIFT = 3;

    // Block field: 8 columns x 9 rows, each block 8 tiles wide, 2 tiles tall
    localparam int BLOCK_START_X_TILE = 8;
    localparam int BLOCK_START_Y_TILE = 4;
    localparam int BLOCK_W_TILES      = 8;
    localparam int BLOCK_H_TILES      = 2;
    localparam int BLOCK_COL_COUNT    = 8;
    localparam int BLOCK_ROW_COUNT    = 9;
    localparam logic [6:0] INVALID_BLOCK_ADDR = 7'd72;

    // Playfield border
    localparam int LEFT_WALL_TILE  = 0;
    localparam int RIGHT_WALL_TILE = 79;
    localparam int CEILING_TILE    = 0;

    // Moving objects
    localparam int PADDLE_Y_PIXEL      = 440;
    localparam int PADDLE_LENGTH_PIXEL = 64;
    localparam int PADDLE_HEIGHT_PIXEL = 8;
    localparam int BALL_SIZE_PIXEL     = 8;

    // 3-3-2 colours
    localparam logic [7:0] BALL_COLOUR   = 8'hFF;
    localparam logic [7:0] PADDLE_COLOUR = 8'hB6;
    localparam logic [7:0] WALL_COLOUR   = 8'h92;
    localparam logic [7:0] BG_COLOUR     = 8'h00;

    typedef enum logic [1:0] {
        FS_WAIT_FIRST,
        FS_ACTIVE,
        FS_VBLANK
    } frame_state_t;

    // Block colour chosen by block row (row modulo 8)
    function automatic logic [7:0] block_palette(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = 8'hE0;
            3'd1:    c = 8'hEC;
            3'd2:    c = 8'hFC;
            3'd3:    c = 8'h1C;
            3'd4:    c = 8'h1F;
            3'd5:    c = 8'h03;
            3'd6:    c = 8'hE3;
            default: c = 8'h6D;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/scene_renderer_block_addr_calc.sv
// Combinational beam pixel -> block-state address, palette row and
// 1-pixel gap flag for the block field.
module block_addr_calc
    import scene_renderer_pkg::*;
(
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    output logic [6:0] o_addr,
    output logic [2:0] o_row_idx,
    output logic       o_gap
);

    logic [6:0] w_x_tile;
    logic [6:0] w_y_tile;
    logic [5:0] w_dx_tile;
    logic [4:0] w_dy_tile;
    logic [2:0] w_col;
    logic [3:0] w_row;
    logic       w_in_grid;

    assign w_x_tile  = i_x[9:TILE_SHIFT];
    assign w_y_tile  = i_y[9:TILE_SHIFT];
    assign w_dx_tile = 6'(w_x_tile - 7'(BLOCK_START_X_TILE));
    assign w_dy_tile = 5'(w_y_tile - 7'(BLOCK_START_Y_TILE));

    // Block width is 8 tiles and height 2 tiles, so column/row are shifts
    assign w_col = w_dx_tile[5:3];
    assign w_row = w_dy_tile[4:1];

    assign w_in_grid = (w_x_tile >= 7'(BLOCK_START_X_TILE)) &&
                       (w_x_tile <  7'(BLOCK_START_X_TILE + BLOCK_COL_COUNT * BLOCK_W_TILES)) &&
                       (w_y_tile >= 7'(BLOCK_START_Y_TILE)) &&
                       (w_y_tile <  7'(BLOCK_START_Y_TILE + BLOCK_ROW_COUNT * BLOCK_H_TILES));

    // Eight columns per row, so row*8+col is a plain concatenation
    assign o_addr    = w_in_grid ? {w_row, w_col} : INVALID_BLOCK_ADDR;
    assign o_row_idx = w_row[2:0];

    // Last pixel column / row of every block is left as background
    assign o_gap = ((w_dx_tile[2:0] == 3'd7) && (i_x[2:0] == 3'd7)) ||
                   (w_dy_tile[0] && (i_y[2:0] == 3'd7));

endmodule

// File: rtl/scene_renderer.sv
// Three-stage scene renderer: classifies the beam pixel, reads block state,
// and produces 3-3-2 RGB with syncs delayed to match. Ball/paddle positions
// are snapshotted once per frame at the frame-tick pulse.
module scene_renderer
    import scene_renderer_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [9:0] X_PIXEL,
    input  logic [9:0] Y_PIXEL,
    input  logic       HSYNC_IN,
    input  logic       VSYNC_IN,
    input  logic [9:0] PADDLE_X_PIXEL,
    input  logic [9:0] BALL_X_PIXEL,
    input  logic [9:0] BALL_Y_PIXEL,
    input  logic       BALL_LOST,
    output logic [6:0] BLOCK_ADDR,
    input  logic       BLOCK_ALIVE,
    output logic       START_UPDATE,
    output logic [7:0] RGB,
    output logic       HSYNC,
    output logic       VSYNC
);

    function automatic logic [7:0] pixel_colour(input logic       active,
                                                input logic       ball,
                                                input logic       paddle,
                                                input logic       block_on,
                                                input logic       wall,
                                                input logic [7:0] block_colour);
        logic [7:0] c;
        if (!active)       c = BG_COLOUR;
        else if (ball)     c = BALL_COLOUR;
        else if (paddle)   c = PADDLE_COLOUR;
        else if (block_on) c = block_colour;
        else if (wall)     c = WALL_COLOUR;
        else               c = BG_COLOUR;
        return c;
    endfunction

    frame_state_t r_state, w_next_state;
    logic         w_start;
    logic         r_start_update;
    logic [7:0]   r_frame_cnt;
    logic [9:0]   r_ball_x, r_ball_y, r_paddle_x;

    logic [6:0]   w_addr;
    logic [2:0]   w_row_idx;
    logic         w_gap;
    logic         w_active, w_ball_hit, w_paddle_hit, w_wall, w_hide;
    logic [10:0]  w_x11, w_y11;

    logic [6:0]   r_block_addr;
    logic         r_vld_p0, r_vld_p1;
    logic         r_hs_p0, r_hs_p1, r_hs_p2;
    logic         r_vs_p0, r_vs_p1, r_vs_p2;
    logic [7:0]   r_rgb_p2;
    logic         r_active_p0, r_ball_p0, r_paddle_p0, r_wall_p0, r_gap_p0;
    logic [7:0]   r_colour_p0;
    logic         r_active_p1, r_ball_p1, r_paddle_p1, r_wall_p1, r_block_on_p1;
    logic [7:0]   r_colour_p1;

    block_addr_calc u_block_addr_calc (
        .i_x       (X_PIXEL),
        .i_y       (Y_PIXEL),
        .o_addr    (w_addr),
        .o_row_idx (w_row_idx),
        .o_gap     (w_gap)
    );

    // Beam classification; object compares at 11 bits so x+size never wraps
    assign w_x11        = {1'b0, X_PIXEL};
    assign w_y11        = {1'b0, Y_PIXEL};
    assign w_active     = (X_PIXEL < 10'(H_ACTIVE)) && (Y_PIXEL < 10'(V_ACTIVE));
    assign w_hide       = BALL_LOST && r_frame_cnt[4];
    assign w_ball_hit   = (w_x11 >= {1'b0, r_ball_x}) &&
                          (w_x11 <  ({1'b0, r_ball_x} + 11'(BALL_SIZE_PIXEL))) &&
                          (w_y11 >= {1'b0, r_ball_y}) &&
                          (w_y11 <  ({1'b0, r_ball_y} + 11'(BALL_SIZE_PIXEL)));
    assign w_paddle_hit = (w_x11 >= {1'b0, r_paddle_x}) &&
                          (w_x11 <  ({1'b0, r_paddle_x} + 11'(PADDLE_LENGTH_PIXEL))) &&
                          (w_y11 >= 11'(PADDLE_Y_PIXEL)) &&
                          (w_y11 <  11'(PADDLE_Y_PIXEL + PADDLE_HEIGHT_PIXEL));
    assign w_wall       = (X_PIXEL[9:TILE_SHIFT] == 7'(LEFT_WALL_TILE))  ||
                          (X_PIXEL[9:TILE_SHIFT] == 7'(RIGHT_WALL_TILE)) ||
                          (Y_PIXEL[9:TILE_SHIFT] == 7'(CEILING_TILE));

    // Frame FSM next state; the tick fires only on the ACTIVE->VBLANK edge
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        case (r_state)
            FS_WAIT_FIRST: begin
                if (X_PIXEL == 10'd0 && Y_PIXEL == 10'd0) w_next_state = FS_ACTIVE;
            end
            FS_ACTIVE: begin
                if (X_PIXEL == 10'd0 && Y_PIXEL == 10'(V_ACTIVE)) begin
                    w_next_state = FS_VBLANK;
                    w_start      = 1'b1;
                end
            end
            FS_VBLANK: begin
                if (X_PIXEL == 10'd0 && Y_PIXEL == 10'd0) w_next_state = FS_ACTIVE;
            end
            default: w_next_state = FS_WAIT_FIRST;
        endcase
    end

    // Frame state, tick pulse, frame counter and once-per-frame position snapshot
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= FS_WAIT_FIRST;
            r_start_update <= 1'b0;
            r_frame_cnt    <= 8'd0;
            r_ball_x       <= 10'd0;
            r_ball_y       <= 10'd0;
            r_paddle_x     <= 10'd0;
        end else begin
            r_state        <= w_next_state;
            r_start_update <= w_start;
            if (r_start_update) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_ball_x    <= BALL_X_PIXEL;
                r_ball_y    <= BALL_Y_PIXEL;
                r_paddle_x  <= PADDLE_X_PIXEL;
            end
        end
    end

    // Pipeline control: valid bits, block address, sync delay line, RGB output
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_block_addr <= INVALID_BLOCK_ADDR;
            r_vld_p0     <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_hs_p0      <= 1'b1;
            r_hs_p1      <= 1'b1;
            r_hs_p2      <= 1'b1;
            r_vs_p0      <= 1'b1;
            r_vs_p1      <= 1'b1;
            r_vs_p2      <= 1'b1;
            r_rgb_p2     <= BG_COLOUR;
        end else begin
            // S1
            r_block_addr <= w_addr;
            r_vld_p0     <= 1'b1;
            r_hs_p0      <= HSYNC_IN;
            r_vs_p0      <= VSYNC_IN;
            // S2
            r_vld_p1     <= r_vld_p0;
            r_hs_p1      <= r_hs_p0;
            r_vs_p1      <= r_vs_p0;
            // S3
            r_hs_p2      <= r_hs_p1;
            r_vs_p2      <= r_vs_p1;
            r_rgb_p2     <= r_vld_p1 ? pixel_colour(r_active_p1, r_ball_p1, r_paddle_p1,
                                                    r_block_on_p1, r_wall_p1, r_colour_p1)
                                     : BG_COLOUR;
        end
    end

    // Pipeline data: classification flags and block colour (no reset needed)
    always_ff @(posedge CLK) begin
        // S1
        r_active_p0   <= w_active;
        r_ball_p0     <= w_ball_hit && !w_hide;
        r_paddle_p0   <= w_paddle_hit && !w_hide;
        r_wall_p0     <= w_wall;
        r_gap_p0      <= w_gap;
        r_colour_p0   <= block_palette(w_row_idx);
        // S2
        r_active_p1   <= r_active_p0;
        r_ball_p1     <= r_ball_p0;
        r_paddle_p1   <= r_paddle_p0;
        r_wall_p1     <= r_wall_p0;
        r_colour_p1   <= r_colour_p0;
        r_block_on_p1 <= BLOCK_ALIVE && !r_gap_p0 && (r_block_addr != INVALID_BLOCK_ADDR);
    end

    assign BLOCK_ADDR   = r_block_addr;
    assign START_UPDATE = r_start_update;
    assign RGB          = r_rgb_p2;
    assign HSYNC        = r_hs_p2;
    assign VSYNC        = r_vs_p2;

endmodule
